// File: rtl/reset_gen_pkg.sv
// reset_gen_pkg: channel state encoding and width helper shared by the reset generator
package reset_gen_pkg;
  typedef enum logic [1:0] {
    RS_RELEASED = 2'b00,
    RS_ASSERTED = 2'b01,
    RS_STRETCH  = 2'b10
  } rst_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/reset_stretch_ch.sv
// reset_stretch_ch: one reset channel, holds its output STRETCH+1 cycles past the last request
module reset_stretch_ch
  import reset_gen_pkg::*;
#(
  parameter int STRETCH = 8,
  parameter bit INIT    = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EFF_IN,
  output logic ASSERTED,
  output logic RST_OUT
);
  localparam int CNT_W = clog2(STRETCH + 1) > 1 ? clog2(STRETCH + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(STRETCH);
  rst_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;
  always_comb begin
    run     = state_q == RS_STRETCH && cnt_q != '0;
    state_d = EFF_IN ? RS_ASSERTED : state_q == RS_ASSERTED ? RS_STRETCH : run ? RS_STRETCH : RS_RELEASED;
    cnt_d   = (EFF_IN || state_q == RS_ASSERTED) ? LOAD : run ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT ? RS_STRETCH : RS_RELEASED;
      cnt_q   <= INIT ? LOAD : '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ASSERTED = state_q == RS_ASSERTED;
  assign RST_OUT  = state_q == RS_ASSERTED || state_q == RS_STRETCH;
endmodule

// File: rtl/make_reset_multi.sv
// make_reset_multi: multi-channel stretched reset generator with optional ordered release
module make_reset_multi
  import reset_gen_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int STRETCH  = 8,
  parameter bit INIT     = 1'b1,
  parameter bit SEQ_MODE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] ASSERT_IN,
  output logic [NUM_CH-1:0] ASSERT_OUT,
  output logic [NUM_CH-1:0] OUT_RST,
  output logic              ALL_RELEASED
);
  logic [NUM_CH-1:0] eff;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // cascade taps the registered output of the channel below, so there is no comb loop
    if (SEQ_MODE && c > 0) begin : g_seq
      assign eff[c] = ASSERT_IN[c] | OUT_RST[c-1];
    end else begin : g_ind
      assign eff[c] = ASSERT_IN[c];
    end
    reset_stretch_ch #(
      .STRETCH(STRETCH),
      .INIT   (INIT)
    ) u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .EFF_IN  (eff[c]),
      .ASSERTED(ASSERT_OUT[c]),
      .RST_OUT (OUT_RST[c])
    );
  end
  assign ALL_RELEASED = ~|OUT_RST;
endmodule
